mvm_stream_loader: RTL
======================

MVM_STREAM_LOADER -- requirements
Module: mvm_stream_loader

Interface
REQ-001 Parameter DATAW, default 512, tdata width of source and tx streams.
REQ-002 Parameter NUM_RFS, default 64, RF one-hot width in tuser.
REQ-003 Parameter ADDRW, default 9, RF address field width.
REQ-004 Parameter USERW, default NUM_RFS+2+ADDRW (75), tuser width.
REQ-005 Parameter CNTW, default 16, command count width.
REQ-006 clk  in  1  single clock, all logic rising-edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 cmd_valid  in  1  command offered.
REQ-009 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-010 cmd_op  in  2  0 instruction, 1 reduction vector, 2 input vector, 3 matrix data.
REQ-011 cmd_addr  in  ADDRW  base RF address.
REQ-012 cmd_count  in  CNTW  beats (ops 0-2) or addresses (op 3).
REQ-013 cmd_rfs  in  7  RFs per address for op 3, ignored otherwise.
REQ-014 src_tvalid / src_tready / src_tdata  in / out / in DATAW  payload source stream.
REQ-015 axis_tx_tvalid / axis_tx_tready  out / in  tx handshake toward the MVM rx port.
REQ-016 axis_tx_tdata  out  DATAW  payload; axis_tx_tuser  out  USERW  {onehot, op, addr}.
REQ-017 axis_tx_tlast  out  1  high on the final beat of a command.
REQ-018 cmd_done  out  1  one-cycle pulse when a command's final beat is accepted on tx.

Function
REQ-019 FSM states IDLE and STREAM; cmd_ready = 1 only in IDLE.
REQ-020 IDLE->STREAM on cmd accept with nonzero beat total; a zero-beat command (cmd_count=0, or op 3 with cmd_rfs=0) stays in IDLE and pulses cmd_done next cycle.
REQ-021 Beat total = cmd_count for ops 0-2; cmd_count*cmd_rfs for op 3; cmd_rfs > NUM_RFS is clamped to NUM_RFS.
REQ-022 src_tready = (state==STREAM) && (!axis_tx_tvalid || axis_tx_tready); one registered output stage; latency 1 cycle; full throughput with tready held high.
REQ-023 tx outputs are stable while axis_tx_tvalid && !axis_tx_tready.
REQ-024 Ops 0-2: tuser onehot = 0, op = cmd_op, addr = cmd_addr on every beat.
REQ-025 Op 3: onehot starts at bit 0 and shifts left each beat; after cmd_rfs beats it returns to bit 0 and addr increments by 1.
REQ-026 Address increments wrap modulo 2^ADDRW (511 -> 0).
REQ-027 STREAM->IDLE in the cycle the last beat is loaded into the output register; tlast set on that beat; cmd_done pulses on its tx acceptance.
REQ-028 A new command is not accepted until the output register has drained its tlast beat.
REQ-029 Source data is never dropped or duplicated; beats beyond the total stay in the source stream.

Reset
REQ-030 On rst low: state IDLE; cmd_ready, src_tready, axis_tx_tvalid, tlast and cmd_done = 0; tdata and tuser = 0; counters cleared.
REQ-031 Reset mid-command abandons it; after release, cmd_ready = 1 on the first clock edge.

Structure
REQ-032 Op encodings (OP_INSTR=0, OP_REDUCE=1, OP_IVEC=2, OP_MATRIX=3) and the tuser field layout live in a shared package, mvm_pkg.
REQ-033 One sub-module, mvm_axis_reg: a single-entry valid/ready output register.

Verification
REQ-034 Op 0, count 8, src words 0..7, tready=1 -> 8 beats in 8 consecutive cycles, tuser = 0, tlast on beat 8, one cmd_done pulse.
REQ-035 Op 3, addr 0x020, count 4, rfs 2 -> 8 beats; tuser = {onehot, 2'h3, addr} with onehot 1,2,1,2,1,2,1,2 and addr 0x020,0x020,0x021,0x021,0x022,0x022,0x023,0x023.
REQ-036 Op 3, addr 0x1FF, count 2, rfs 1 -> addr 0x1FF then 0x000.
REQ-037 Op 2, count 200, random tready backpressure -> stable outputs while stalled, tx data equals source order, exactly 200 beats.
REQ-038 Op 2, count 0 -> no tx beats; cmd_done pulses one cycle later; cmd_ready is high again.
REQ-039 rst asserted after beat 3 of a 10-beat command -> tvalid drops immediately; after release a new 2-beat command completes correctly.

Source files
------------

// File: rtl/mvm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : mvm_pkg                                                         |
// | Purpose   : Shared definitions for the MVM stream loader: command op        |
// |             encodings, loader FSM states and the tuser field layout.        |
// | Revision  : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package mvm_pkg;

  // Width of the op field carried in tuser.
  localparam int OP_W  = 2;
  // Width of the per-command RF count for matrix writes.
  localparam int RFS_W = 7;

  // Command op encodings.
  typedef enum logic [OP_W-1:0] {
    OP_INSTR  = 2'd0,
    OP_REDUCE = 2'd1,
    OP_IVEC   = 2'd2,
    OP_MATRIX = 2'd3
  } op_e;

  // Loader FSM states.
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  // tuser layout, MSB to LSB: {rf_onehot[num_rfs-1:0], op[OP_W-1:0], addr[addrw-1:0]}
  function automatic int tuser_w(input int num_rfs, input int addrw);
    return num_rfs + OP_W + addrw;
  endfunction

  // Saturate a requested RF count to the number of RFs present.
  function automatic logic [RFS_W-1:0] clamp_rfs(input logic [RFS_W-1:0] rfs,
                                                 input int              max_rfs);
    if (int'(rfs) > max_rfs) begin
      return RFS_W'(max_rfs);
    end
    return rfs;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mvm_axis_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : mvm_axis_reg                                                    |
// | Purpose   : Single-entry valid/ready register slice. Output data is held    |
// |             stable while out_valid_o is high and out_ready_i is low.        |
// | Ports     : clk, rst (async, active-low)                                    |
// |             in_valid_i/in_ready_o/in_data_i    upstream handshake          |
// |             out_valid_o/out_ready_i/out_data_o downstream handshake        |
// | Revision  : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mvm_axis_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  // The slot can take a new word when empty or when its current word leaves.
  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_ready_o) begin
      valid_q <= in_valid_i;
      if (in_valid_i) begin
        data_q <= in_data_i;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mvm_stream_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : mvm_stream_loader                                               |
// | Purpose   : Turns load commands into an AXI-stream toward the MVM rx port.  |
// |             Payload words come from src_*, each beat is tagged in tuser     |
// |             with {rf onehot, op, rf address}.                               |
// | Ports     : clk, rst (async, active-low)                                    |
// |             cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_count/cmd_rfs  command |
// |             src_tvalid/src_tready/src_tdata                    payload in  |
// |             axis_tx_tvalid/tready/tdata/tuser/tlast            stream out  |
// |             cmd_done                       pulse on last beat acceptance   |
// | Revision  : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mvm_stream_loader
  import mvm_pkg::*;
#(
  parameter int DATAW   = 512,
  parameter int NUM_RFS = 64,
  parameter int ADDRW   = 9,
  parameter int USERW   = tuser_w(NUM_RFS, ADDRW),
  parameter int CNTW    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic [ADDRW-1:0] cmd_addr,
  input  logic [CNTW-1:0]  cmd_count,
  input  logic [RFS_W-1:0] cmd_rfs,
  input  logic             src_tvalid,
  output logic             src_tready,
  input  logic [DATAW-1:0] src_tdata,
  output logic             axis_tx_tvalid,
  input  logic             axis_tx_tready,
  output logic [DATAW-1:0] axis_tx_tdata,
  output logic [USERW-1:0] axis_tx_tuser,
  output logic             axis_tx_tlast,
  output logic             cmd_done
);

  // Beat total can reach cmd_count * NUM_RFS, so it needs the RF count bits too.
  localparam int TOTW = CNTW + RFS_W;
  localparam int PAYW = DATAW + USERW + 1;

  state_e           state_q, state_d;
  logic [TOTW-1:0]  remain_q, remain_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [RFS_W-1:0] rfs_q, rfs_d;
  logic [RFS_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;

  logic             in_ready;
  logic             load;
  logic             cmd_fire;
  logic             tx_fire;
  logic [RFS_W-1:0] rfs_clamp;
  logic [TOTW-1:0]  cmd_total;
  logic [NUM_RFS-1:0] onehot;
  logic             beat_last;
  logic [PAYW-1:0]  in_payload;
  logic [PAYW-1:0]  out_payload;

  // Holding off until the tx register is empty guarantees the previous
  // command's tlast beat has drained before a new one starts. Gating with
  // rst keeps ready low while reset is held.
  assign cmd_ready = rst && (state_q == ST_IDLE) && !axis_tx_tvalid;
  assign cmd_fire  = cmd_valid && cmd_ready;

  assign rfs_clamp = clamp_rfs(cmd_rfs, NUM_RFS);
  assign cmd_total = (cmd_op == OP_MATRIX) ? TOTW'(cmd_count) * TOTW'(rfs_clamp)
                                           : TOTW'(cmd_count);

  assign src_tready = (state_q == ST_STREAM) && in_ready;
  assign load       = src_tvalid && src_tready;
  assign tx_fire    = axis_tx_tvalid && axis_tx_tready;

  assign onehot     = (op_q == OP_MATRIX) ? ({{(NUM_RFS-1){1'b0}}, 1'b1} << idx_q) : '0;
  assign beat_last  = (remain_q == TOTW'(1));
  assign in_payload = {beat_last, onehot, op_q, addr_q, src_tdata};

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    op_d     = op_q;
    addr_d   = addr_q;
    rfs_d    = rfs_q;
    idx_d    = idx_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          op_d     = cmd_op;
          addr_d   = cmd_addr;
          rfs_d    = rfs_clamp;
          idx_d    = '0;
          remain_d = cmd_total;
          if (cmd_total != '0) begin
            state_d = ST_STREAM;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_STREAM: begin
        if (load) begin
          remain_d = remain_q - TOTW'(1);
          if (beat_last) begin
            state_d = ST_IDLE;
          end
          // Matrix data walks across rfs_q RFs at one address, then moves on.
          if (op_q == OP_MATRIX) begin
            if (idx_q == rfs_q - RFS_W'(1)) begin
              idx_d  = '0;
              addr_d = addr_q + ADDRW'(1);
            end else begin
              idx_d = idx_q + RFS_W'(1);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (tx_fire && axis_tx_tlast) begin
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      remain_q <= '0;
      op_q     <= '0;
      addr_q   <= '0;
      rfs_q    <= '0;
      idx_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      rfs_q    <= rfs_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
    end
  end

  assign cmd_done = done_q;

  mvm_axis_reg #(
    .W (PAYW)
  ) u_out_reg (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (load),
    .in_ready_o  (in_ready),
    .in_data_i   (in_payload),
    .out_valid_o (axis_tx_tvalid),
    .out_ready_i (axis_tx_tready),
    .out_data_o  (out_payload)
  );

  assign axis_tx_tlast = out_payload[PAYW-1];
  assign axis_tx_tuser = out_payload[DATAW +: USERW];
  assign axis_tx_tdata = out_payload[DATAW-1:0];

endmodule
`default_nettype wire
